// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- stall/flush sequencer for the 5-stage pipeline
//
// Generates the load enables for the PC, FD, DX, XM and MW pipeline
// registers and the bubble-insert (flush) controls for FD, DX and XM.
// Four hazards are resolved under one priority order:
//   data-memory stall > taken branch > load-use > instruction-memory stall
// A HALT in writeback stops the pipeline until reset. A data access that
// stays outstanding too long stops it with a sticky error.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   FD_rs, FD_rt              decode source registers
//   FD_useRs, FD_useRt        decode instruction reads that source
//   DX_rd, DX_memRead         execute destination register / is a load
//   branchTaken               execute stage redirect
//   imemStall                 fetch not ready this cycle
//   XM_memRead, XM_memWrite   memory-stage load / store
//   dmemDone                  data access complete
//   halt                      HALT in writeback
//   pc_en, FD_en .. MW_en     register load enables
//   FD_flush .. XM_flush      load a bubble into that register
//   dmem_req                  one-cycle data access start strobe
//   halted, err               sticky stop indications
//   stall_cnt, flush_cnt      statistics counters
//
// Optional feature macro: PIPE_CTRL_STATS_EN
//   defined   : stall_cnt / flush_cnt count stall cycles and redirects,
//               saturating at 16'hFFFF
//   undefined : both read as 0 and no counter flops exist
//
// Handshake note: dmem_req is a start strobe, high only in the RUN cycle
// in which a memory-stage access is seen. dmemDone may be high in that
// same cycle (zero-wait access) or in any later cycle; the access is
// complete in the first cycle dmemDone is sampled high.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  FD_rs,
    input  logic [2:0]  FD_rt,
    input  logic        FD_useRs,
    input  logic        FD_useRt,
    input  logic [2:0]  DX_rd,
    input  logic        DX_memRead,
    input  logic        branchTaken,
    input  logic        imemStall,
    input  logic        XM_memRead,
    input  logic        XM_memWrite,
    input  logic        dmemDone,
    input  logic        halt,
    output logic        pc_en,
    output logic        FD_en,
    output logic        DX_en,
    output logic        XM_en,
    output logic        MW_en,
    output logic        FD_flush,
    output logic        DX_flush,
    output logic        XM_flush,
    output logic        dmem_req,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_HALTED = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    logic load_use;
    logic mem_access;

    // R0 is a real register, so a destination of 0 still creates a hazard.
    assign load_use = DX_memRead &&
                      ((FD_useRs && (FD_rs == DX_rd)) ||
                       (FD_useRt && (FD_rt == DX_rd)));

    assign mem_access = XM_memRead | XM_memWrite;

    always_comb begin
        pc_en    = 1'b0;
        FD_en    = 1'b0;
        DX_en    = 1'b0;
        XM_en    = 1'b0;
        MW_en    = 1'b0;
        FD_flush = 1'b0;
        DX_flush = 1'b0;
        XM_flush = 1'b0;
        dmem_req = 1'b0;
        state_d  = state_q;
        wd_d     = wd_q;

        if (!rst) begin
            unique case (state_q)
                S_RUN: begin
                    if (halt) begin
                        state_d = S_HALTED;
                    end else begin
                        dmem_req = mem_access;
                        if (mem_access && !dmemDone) begin
                            // Whole pipeline freezes, including the request cycle.
                            state_d = S_DWAIT;
                            wd_d    = CNT_W'(1);
                        end else begin
                            pc_en = 1'b1;
                            FD_en = 1'b1;
                            DX_en = 1'b1;
                            XM_en = 1'b1;
                            MW_en = 1'b1;
                            if (branchTaken) begin
                                // Target loads into PC; squash the two wrong-path instrs.
                                FD_flush = 1'b1;
                                DX_flush = 1'b1;
                            end else if (load_use) begin
                                // Hold PC/FD, one bubble into DX; clears itself next cycle.
                                pc_en    = 1'b0;
                                FD_en    = 1'b0;
                                DX_flush = 1'b1;
                            end else if (imemStall) begin
                                pc_en    = 1'b0;
                                FD_flush = 1'b1;
                            end
                        end
                    end
                end
                S_DWAIT: begin
                    if (halt) begin
                        state_d = S_HALTED;
                        wd_d    = '0;
                    end else if (dmemDone) begin
                        // Release this cycle; frozen hazards are re-evaluated in RUN.
                        pc_en   = 1'b1;
                        FD_en   = 1'b1;
                        DX_en   = 1'b1;
                        XM_en   = 1'b1;
                        MW_en   = 1'b1;
                        state_d = S_RUN;
                        wd_d    = '0;
                    end else if (wd_q == TIMEOUT_C) begin
                        state_d = S_ERR;
                    end else begin
                        wd_d = wd_q + CNT_W'(1);
                    end
                end
                default: begin
                    // HALTED and ERR hold everything off until reset.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    assign halted = (state_q == S_HALTED);
    assign err    = (state_q == S_ERR);

`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        redirect;

    // Only a taken branch raises pc_en together with FD_flush.
    assign redirect = pc_en & FD_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q == S_RUN || state_q == S_DWAIT) && !pc_en &&
                (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (redirect && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int TMO = 4;
`ifdef PIPE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  FD_rs, FD_rt, DX_rd;
  logic        FD_useRs, FD_useRt, DX_memRead, branchTaken, imemStall;
  logic        XM_memRead, XM_memWrite, dmemDone, halt;
  logic        pc_en, FD_en, DX_en, XM_en, MW_en;
  logic        FD_flush, DX_flush, XM_flush, dmem_req, halted, err;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .FD_rs(FD_rs), .FD_rt(FD_rt), .FD_useRs(FD_useRs), .FD_useRt(FD_useRt),
    .DX_rd(DX_rd), .DX_memRead(DX_memRead), .branchTaken(branchTaken),
    .imemStall(imemStall), .XM_memRead(XM_memRead), .XM_memWrite(XM_memWrite),
    .dmemDone(dmemDone), .halt(halt),
    .pc_en(pc_en), .FD_en(FD_en), .DX_en(DX_en), .XM_en(XM_en), .MW_en(MW_en),
    .FD_flush(FD_flush), .DX_flush(DX_flush), .XM_flush(XM_flush),
    .dmem_req(dmem_req), .halted(halted), .err(err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  // ---------------- behavioural model ----------------
  // Pipeline condition: stopped by HALT, stopped by error, or number of
  // cycles an access has been waiting (0 = no access outstanding).
  bit m_halted = 1'b0;
  bit m_err = 1'b0;
  int m_wait = 0;
  int m_stall = 0;
  int m_flush = 0;

  // Returns {pc,fd,dx,xm,mw,fd_flush,dx_flush,xm_flush,dmem_req,redirect}
  function automatic logic [9:0] model_out();
    logic pc, fd, dx, xm, mw, fdf, dxf, req, redir;
    bit lu;
    pc = 0; fd = 0; dx = 0; xm = 0; mw = 0; fdf = 0; dxf = 0; req = 0; redir = 0;
    lu = DX_memRead && ((FD_useRs && FD_rs == DX_rd) || (FD_useRt && FD_rt == DX_rd));
    if (rst || m_halted || m_err || halt) begin
      // everything held off
    end else if (m_wait > 0) begin
      {pc, fd, dx, xm, mw} = {5{dmemDone}};
    end else begin
      req = XM_memRead | XM_memWrite;
      if (!(req && !dmemDone)) begin
        {pc, fd, dx, xm, mw} = 5'b11111;
        if (branchTaken) begin
          fdf = 1; dxf = 1; redir = 1;
        end else if (lu) begin
          pc = 0; fd = 0; dxf = 1;
        end else if (imemStall) begin
          pc = 0; fdf = 1;
        end
      end
    end
    return {pc, fd, dx, xm, mw, fdf, dxf, 1'b0, req, redir};
  endfunction

  initial forever begin
    logic [9:0] e;
    @(posedge clk);
    e = model_out();
    if (rst) begin
      m_halted = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (STATS) begin
        if (!m_halted && !m_err && !e[9] && m_stall < 65535) m_stall = m_stall + 1;
        if (e[0] && m_flush < 65535) m_flush = m_flush + 1;
      end
      if (m_halted || m_err) begin
        // terminal
      end else if (halt) begin
        m_halted = 1; m_wait = 0;
      end else if (m_wait > 0) begin
        if (dmemDone) m_wait = 0;
        else if (m_wait == TMO) m_err = 1;
        else m_wait = m_wait + 1;
      end else if ((XM_memRead | XM_memWrite) && !dmemDone) begin
        m_wait = 1;
      end
    end
  end

  // ---------------- compare process (every cycle) ----------------
  initial forever begin
    logic [9:0] e;
    logic [8:0] act;
    @(negedge clk);
    if (cmp_on) begin
      e = model_out();
      act = {pc_en, FD_en, DX_en, XM_en, MW_en, FD_flush, DX_flush, XM_flush, dmem_req};
      checks++;
      if (act !== e[9:1]) begin
        failures++;
        $display("FAIL ctrl t=%0t got=%b exp=%b", $time, act, e[9:1]);
      end
      checks++;
      if ({halted, err} !== {m_halted, m_err}) begin
        failures++;
        $display("FAIL status t=%0t got=%b exp=%b", $time, {halted, err}, {m_halted, m_err});
      end
      checks++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
        failures++;
        $display("FAIL counters t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                 stall_cnt, flush_cnt, m_stall, m_flush);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    FD_rs = 0; FD_rt = 0; FD_useRs = 0; FD_useRt = 0; DX_rd = 0; DX_memRead = 0;
    branchTaken = 0; imemStall = 0; XM_memRead = 0; XM_memWrite = 0;
    dmemDone = 0; halt = 0;
  endtask

  task automatic rand_inputs();
    FD_rs = 3'($urandom_range(0, 7));
    FD_rt = 3'($urandom_range(0, 7));
    DX_rd = 3'($urandom_range(0, 7));
    FD_useRs = ($urandom_range(0, 1) == 1);
    FD_useRt = ($urandom_range(0, 1) == 1);
    DX_memRead = ($urandom_range(0, 2) == 0);
    branchTaken = ($urandom_range(0, 5) == 0);
    imemStall = ($urandom_range(0, 4) == 0);
    XM_memRead = ($urandom_range(0, 7) == 0);
    XM_memWrite = ($urandom_range(0, 7) == 0);
    dmemDone = ($urandom_range(0, 1) == 1);
    halt = ($urandom_range(0, 149) == 0);
  endtask

  task automatic do_reset();
    rst = 1; idle();
    @(negedge clk);
    tick();
    rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    int zeros;
    rst = 1; idle();
    cmp_on = 1;

    // Reset state
    @(negedge clk);
    chk("rst_outputs", {pc_en, FD_en, DX_en, XM_en, MW_en, FD_flush, DX_flush, dmem_req}, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("run_idle_en", {pc_en, FD_en, DX_en, XM_en, MW_en}, 5'b11111);
    chk("run_idle_sts", {halted, err, stall_cnt, flush_cnt}, 0);
    tick();

    // Load-use: exactly one bubble
    do_reset();
    DX_memRead = 1; DX_rd = 3; FD_rs = 3; FD_useRs = 1;
    @(negedge clk);
    chk("lu_bubble", {pc_en, FD_en, DX_en, DX_flush, FD_flush}, 5'b00110);
    tick();
    DX_memRead = 0;
    @(negedge clk);
    chk("lu_release", {pc_en, FD_en, DX_en, XM_en, MW_en, DX_flush}, 6'b111110);
    chk("lu_stall_cnt", stall_cnt, STATS ? 1 : 0);
    tick();
    // R0 destination still matches
    DX_memRead = 1; DX_rd = 0; FD_rt = 0; FD_useRt = 1; FD_useRs = 0;
    @(negedge clk);
    chk("lu_r0", {pc_en, FD_en, DX_flush}, 3'b001);
    tick();

    // Data access: request + 3 wait cycles frozen, release on done
    do_reset();
    XM_memRead = 1; dmemDone = 0;
    pulses = 0; zeros = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) dmemDone = 1;
      @(negedge clk);
      if (k == 0) chk("dmem_req_first", dmem_req, 1);
      if (k == 4) chk("dmem_release", {pc_en, FD_en, DX_en, XM_en, MW_en}, 5'b11111);
      pulses += int'(dmem_req);
      if ({pc_en, FD_en, DX_en, XM_en, MW_en} == 5'b00000) zeros++;
      tick();
    end
    XM_memRead = 0; dmemDone = 0;
    @(negedge clk);
    pulses += int'(dmem_req);
    chk("dmem_pulses", pulses, 1);
    chk("dmem_frozen_cycles", zeros, 4);
    tick();

    // Branch overrides load-use and imem stall
    do_reset();
    DX_memRead = 1; DX_rd = 5; FD_rs = 5; FD_useRs = 1; imemStall = 1; branchTaken = 1;
    @(negedge clk);
    chk("br_over_lu", {pc_en, FD_en, FD_flush, DX_flush}, 4'b1111);
    tick();
    idle();
    @(negedge clk);
    chk("br_flush_cnt", flush_cnt, STATS ? 1 : 0);
    tick();

    // Timeout: 4 wait cycles then err, sticky until reset
    do_reset();
    XM_memWrite = 1; dmemDone = 0;
    @(negedge clk);
    chk("tmo_req", dmem_req, 1);
    tick();
    zeros = 0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if ({pc_en, FD_en, DX_en, XM_en, MW_en, err} == 6'b000000) zeros++;
      tick();
    end
    chk("tmo_wait_cycles", zeros, TMO);
    @(negedge clk);
    chk("tmo_err", {err, pc_en, FD_en, DX_en, XM_en, MW_en}, 6'b100000);
    tick();
    rst = 1; idle();
    @(negedge clk);
    tick();
    rst = 0;
    @(negedge clk);
    chk("tmo_cleared", {err, pc_en}, 2'b01);
    tick();

    // Halt wins over imem stall, holds until reset
    do_reset();
    halt = 1; imemStall = 1;
    @(negedge clk);
    tick();
    for (int k = 0; k < 5; k++) begin
      rand_inputs();
      @(negedge clk);
      chk("halt_hold", {halted, pc_en, FD_en, DX_en, XM_en, MW_en, dmem_req}, 7'b1000000);
      tick();
    end
    do_reset();
    @(negedge clk);
    chk("halt_cleared", halted, 0);
    tick();

    // Imem stall for two cycles
    imemStall = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("imem_stall", {pc_en, FD_flush, FD_en, DX_en, XM_en, MW_en}, 6'b011111);
      tick();
    end
    imemStall = 0;

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if (m_halted || m_err) rst = ($urandom_range(0, 3) == 0);
      else rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      tick();
    end

    rst = 1; idle();
    @(negedge clk);
    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
